// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the NPC core sequencer: opcodes, ebreak encoding,
// FSM state encoding and reset defaults.
package core_seq_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_FETCH_REQ  = 3'd0,
        ST_FETCH_WAIT = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXEC       = 3'd3,
        ST_MEM_REQ    = 3'd4,
        ST_MEM_WAIT   = 3'd5,
        ST_WB         = 3'd6,
        ST_HALT       = 3'd7
    } state_e;

    typedef struct packed {
        logic supported;
        logic writes_rd;
        logic is_mem;
        logic is_system;
    } opc_info_t;

endpackage

// File: rtl/core_seq_ctrl_opc_class.sv
// Combinational opcode classifier: maps a 7-bit opcode to the properties the
// sequencer needs to pick its path through the FSM.
module opc_class
    import core_seq_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opc_info_t  info_o
);

    always_comb begin
        info_o = '0;
        unique case (opcode_i)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP_IMM, OPC_OP, OPC_OP_IMM32, OPC_OP32: begin
                info_o.supported = 1'b1;
                info_o.writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                info_o.supported = 1'b1;
                info_o.writes_rd = 1'b1;
                info_o.is_mem    = 1'b1;
            end
            OPC_STORE: begin
                info_o.supported = 1'b1;
                info_o.is_mem    = 1'b1;
            end
            OPC_BRANCH, OPC_MISC_MEM: info_o.supported = 1'b1;
            // Only ebreak is legal here; the sequencer checks the full word.
            OPC_SYSTEM: begin
                info_o.supported = 1'b1;
                info_o.is_system = 1'b1;
            end
            default: info_o = '0;
        endcase
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns PC and IR, runs the
// fetch/decode/execute/memory/writeback steps and halts on ebreak or faults.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o,
    input  logic [6:0]  opcode_i,
    input  logic [63:0] npc_i,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic        rf_we,
    output logic        halt_o,
    output logic        illegal_o,
    output logic [63:0] instret_o,
    output logic [63:0] cycle_o
);

    // state      | meaning
    // FETCH_REQ  | imem request raised, waiting for ready
    // FETCH_WAIT | waiting for instruction word
    // DECODE     | classify opcode, catch ebreak / illegal
    // EXEC       | route to memory or straight to writeback
    // MEM_REQ    | dmem request raised, waiting for ready
    // MEM_WAIT   | waiting for load data / store completion
    // WB         | commit PC, retire, pulse rf_we
    // HALT       | absorbing until reset

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        halt_q, halt_d;
    logic        illegal_q, illegal_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] cycle_q;
    opc_info_t   info;

    opc_class u_opc_class (
        .opcode_i (opcode_i),
        .info_o   (info)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            instret_q <= '0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            halt_q    <= halt_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
            cycle_q   <= cycle_q + 64'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        halt_d         = halt_q;
        illegal_d      = illegal_q;
        instret_d      = instret_q;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        rf_we          = 1'b0;
        unique case (state_q)
            ST_FETCH_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) state_d = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_d  = imem_rsp_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (inst_q == EBREAK_INST) begin
                    halt_d  = 1'b1;
                    state_d = ST_HALT;
                end else if (!info.supported || info.is_system) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = info.is_mem ? ST_MEM_REQ : ST_WB;
            ST_MEM_REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (dmem_rsp_valid) state_d = ST_WB;
            end
            ST_WB: begin
                // A misaligned target faults before anything is committed.
                if (npc_i[1:0] != 2'b00) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    pc_d      = npc_i;
                    instret_d = instret_q + 64'd1;
                    rf_we     = info.writes_rd;
                    state_d   = ST_FETCH_REQ;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        // Reset is synchronous, so outputs must be masked while it is held.
        if (rst) begin
            imem_req_valid = 1'b0;
            dmem_req_valid = 1'b0;
            rf_we          = 1'b0;
        end
    end

    assign imem_addr = pc_q;
    assign pc_o      = pc_q;
    assign inst_o    = inst_q;
    assign halt_o    = halt_q;
    assign illegal_o = illegal_q;
    assign instret_o = instret_q;
    assign cycle_o   = cycle_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: acts as imem, dmem and decode,
// with a scoreboard of expected fetch addresses and per-instruction results.
module tb_core_seq_ctrl;

    localparam logic [63:0] RPC = 64'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst_o;
    logic [63:0] pc_o;
    logic [6:0]  opcode_i;
    logic [63:0] npc_i;
    logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
    logic        rf_we, halt_o, illegal_o;
    logic [63:0] instret_o, cycle_o;

    int n_checks = 0;
    int n_errors = 0;
    int tcyc;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] pc_after;
        int          cyc;
        int          rfwe;
    } exp_t;
    exp_t sb_q[$];
    exp_t cur;

    core_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_o(inst_o), .pc_o(pc_o),
        .opcode_i(opcode_i), .npc_i(npc_i),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid), .rf_we(rf_we), .halt_o(halt_o),
        .illegal_o(illegal_o), .instret_o(instret_o), .cycle_o(cycle_o)
    );

    // The bench plays the decode unit: opcode is the low 7 bits of the IR.
    assign opcode_i = inst_o[6:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; npc_i = '0;
        repeat (3) step();
        check("rst_valids", {62'd0, imem_req_valid, dmem_req_valid}, 64'd0);
        rst = 1'b0;
        #1;
        tcyc = 0;
    endtask

    task automatic push(input logic [63:0] addr, input logic [63:0] pc_after,
                        input int cyc, input int rfwe);
        exp_t e;
        e.addr = addr; e.pc_after = pc_after; e.cyc = cyc; e.rfwe = rfwe;
        sb_q.push_back(e);
    endtask

    // Entered in a cycle where FETCH_REQ is active; returns at the next
    // fetch request or once a halt/illegal flag is seen.
    task automatic run_inst(input logic [31:0] inst, input logic [63:0] npc, input int dly,
                            output int cyc, output int rfwe_cnt, output int rfwe_at,
                            output int dlen, output bit drop);
        bit ipend, dpend, done, dseen, dacc;
        int dcnt;
        ipend = 0; dpend = 0; done = 0; dseen = 0; dacc = 0; dcnt = 0;
        cyc = 0; rfwe_cnt = 0; rfwe_at = 0; dlen = 0; drop = 0;
        npc_i = npc;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0 && (imem_req_valid || halt_o || illegal_o)) begin
                done = 1;
                cyc  = k;
            end else begin
                if (rf_we) begin rfwe_cnt++; rfwe_at = k + 1; end
                if (dmem_req_valid) begin dlen++; dseen = 1; end
                else if (dseen && !dacc) drop = 1;
                imem_rsp_valid = ipend;
                imem_rsp_data  = ipend ? inst : 32'hDEAD_BEEF;
                ipend = 0;
                dmem_rsp_valid = dpend;
                dpend = 0;
                dmem_req_ready = 1'b0;
                if (k == 0) begin
                    check("fetch_valid", {63'd0, imem_req_valid}, 64'd1);
                    if (sb_q.size() == 0) begin
                        check("sb_empty", 64'd0, 64'd1);
                    end else begin
                        cur = sb_q.pop_front();
                        check("fetch_addr", imem_addr, cur.addr);
                    end
                    ipend = 1;
                end
                if (dmem_req_valid) begin
                    if (dcnt == dly) begin dmem_req_ready = 1'b1; dpend = 1; dacc = 1; end
                    else dcnt++;
                end
                step();
            end
        end
        imem_rsp_valid = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
        if (!done) check("timeout", 64'd0, 64'd1);
        tcyc += cyc;
    endtask

    task automatic issue(input string tag, input logic [31:0] inst, input logic [63:0] npc,
                         input int dly, output int rfwe_at, output int dlen, output bit drop);
        int cyc, rc;
        run_inst(inst, npc, dly, cyc, rc, rfwe_at, dlen, drop);
        check({tag, "_cycles"}, 64'(cyc), 64'(cur.cyc));
        check({tag, "_rfwe"}, 64'(rc), 64'(cur.rfwe));
        check({tag, "_pc"}, pc_o, cur.pc_after);
        check({tag, "_ir"}, {32'd0, inst_o}, {32'd0, inst});
    endtask

    initial begin
        int  at, dl;
        bit  dr, seen;
        do_reset();
        check("rst_pc", pc_o, RPC);
        check("rst_addr", imem_addr, RPC);
        check("rst_ir", {32'd0, inst_o}, {32'd0, NOP});
        check("rst_flags", {61'd0, halt_o, illegal_o, rf_we}, 64'd0);
        check("rst_cnt", instret_o | cycle_o, 64'd0);
        check("rst_ivalid", {63'd0, imem_req_valid}, 64'd1);

        // addi, lw (ready late), sw, taken beq, lui at branch target, ebreak
        push(RPC, 64'h8000_0004, 5, 1);
        issue("addi", 32'h0050_0093, 64'h8000_0004, 0, at, dl, dr);
        check("addi_rfwe_cycle", 64'(at), 64'd5);
        check("addi_instret", instret_o, 64'd1);
        check("addi_cycle_o", cycle_o, 64'd5);

        push(64'h8000_0004, 64'h8000_0008, 10, 1);
        issue("lw", 32'h0000_A103, 64'h8000_0008, 3, at, dl, dr);
        check("lw_dvalid_len", 64'(dl), 64'd4);
        check("lw_no_drop", {63'd0, dr}, 64'd0);

        push(64'h8000_0008, 64'h8000_000C, 7, 0);
        issue("sw", 32'h0020_A023, 64'h8000_000C, 0, at, dl, dr);
        check("sw_dvalid_len", 64'(dl), 64'd1);

        push(64'h8000_000C, 64'h8000_0100, 5, 0);
        issue("beq", 32'h0000_0463, 64'h8000_0100, 0, at, dl, dr);

        push(64'h8000_0100, 64'h8000_0104, 5, 1);
        issue("lui", 32'h0000_10B7, 64'h8000_0104, 0, at, dl, dr);
        check("lui_instret", instret_o, 64'd5);

        push(64'h8000_0104, 64'h8000_0104, 3, 0);
        issue("ebreak", 32'h0010_0073, 64'h8000_0108, 0, at, dl, dr);
        check("ebreak_flags", {62'd0, halt_o, illegal_o}, 64'd2);
        seen = 0;
        repeat (10) begin
            step();
            tcyc++;
            if (imem_req_valid || dmem_req_valid || rf_we) seen = 1;
        end
        check("halt_quiet", {63'd0, seen}, 64'd0);
        check("halt_instret", instret_o, 64'd5);
        check("halt_cycle_o", cycle_o, 64'(tcyc));

        // unknown opcode
        do_reset();
        push(RPC, RPC, 3, 0);
        issue("badopc", 32'hFFFF_FFFF, 64'h8000_0004, 0, at, dl, dr);
        check("badopc_flags", {62'd0, halt_o, illegal_o}, 64'd1);
        check("badopc_instret", instret_o, 64'd0);

        // misaligned jalr target
        do_reset();
        push(RPC, RPC, 5, 0);
        issue("jalr_mis", 32'h0000_80E7, 64'h8000_0002, 0, at, dl, dr);
        check("jalr_mis_flags", {62'd0, halt_o, illegal_o}, 64'd1);
        check("jalr_mis_instret", instret_o, 64'd0);
        seen = 0;
        repeat (4) begin
            step();
            if (imem_req_valid) seen = 1;
        end
        check("jalr_mis_quiet", {63'd0, seen}, 64'd0);

        // reset pulse in MEM_WAIT, then a spurious response in FETCH_REQ
        do_reset();
        imem_req_ready = 1'b1;
        npc_i = 64'h8000_0004;
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_A103;
        step();
        imem_rsp_valid = 1'b0;
        step();
        step();
        check("mw_dvalid", {63'd0, dmem_req_valid}, 64'd1);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        check("mw_rst_valids", {62'd0, imem_req_valid, dmem_req_valid}, 64'd0);
        check("mw_rst_pc", pc_o, RPC);
        check("mw_rst_ir", {32'd0, inst_o}, {32'd0, NOP});
        check("mw_rst_cnt", instret_o | cycle_o, 64'd0);
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        #1;
        check("mw_ivalid", {63'd0, imem_req_valid}, 64'd1);
        step();
        step();
        check("mw_spur_ir", {32'd0, inst_o}, {32'd0, NOP});
        check("mw_hold_addr", {63'd0, imem_req_valid}, 64'd1);
        imem_rsp_valid = 1'b0;
        push(RPC, 64'h8000_0004, 5, 1);
        issue("mw_addi", 32'h0050_0093, 64'h8000_0004, 0, at, dl, dr);
        check("mw_instret", instret_o, 64'd1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle sequencer for the NPC core. It owns the PC and instruction register, fetches instructions over an instruction-memory handshake, and presents the fetched word and its PC to the decode unit. It steps each instruction through decode, execute, optional memory access and writeback, then halts on `ebreak` or on an illegal or misaligned condition. It is the only block that issues register-file write strobes and PC updates.

## Interface
Parameters:
- `RESET_PC`, 64'h8000_0000: PC loaded on reset.
- `NOP_INST`, 32'h0000_0013: instruction register value on reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `imem_req_valid`  out  1  fetch request; held until accepted.
- `imem_req_ready`  in  1  fetch request accepted.
- `imem_addr`  out  64  fetch address, equal to the current PC.
- `imem_rsp_valid`  in  1  fetch data valid.
- `imem_rsp_data`  in  32  fetched instruction.
- `inst_o`  out  32  instruction register, fed to decode.
- `pc_o`  out  64  PC of `inst_o`, fed to decode.
- `opcode_i`  in  7  opcode returned by decode.
- `npc_i`  in  64  next PC resolved by execute (pc+4, branch target or jump target).
- `dmem_req_valid`  out  1  load/store request; held until accepted.
- `dmem_req_ready`  in  1  data request accepted.
- `dmem_rsp_valid`  in  1  load data returned or store completed.
- `rf_we`  out  1  register-file write strobe; a one-cycle pulse.
- `halt_o`  out  1  sticky flag, set by `ebreak`.
- `illegal_o`  out  1  sticky flag, set by an unknown opcode or a misaligned `npc_i`.
- `instret_o`  out  64  count of retired instructions.
- `cycle_o`  out  64  count of cycles since reset.

## Operation
States and transitions:
- FETCH_REQ: drive `imem_req_valid`=1.
  - `imem_req_ready`=1 -> FETCH_WAIT.
- FETCH_WAIT: sample `imem_rsp_valid`.
  - When it is 1, load `inst_o` from `imem_rsp_data` -> DECODE.
- DECODE: one cycle; classify `opcode_i`.
  - `inst_o`==32'h0010_0073 -> HALT, set `halt_o`.
  - Any other SYSTEM opcode, or an opcode outside the supported set -> HALT, set `illegal_o`.
  - Otherwise -> EXEC.
- EXEC: one cycle.
  - LOAD 0000011 or STORE 0100011 -> MEM_REQ.
  - All other opcodes -> WB.
- MEM_REQ: drive `dmem_req_valid`=1.
  - `dmem_req_ready`=1 -> MEM_WAIT.
- MEM_WAIT: sample `dmem_rsp_valid`.
  - When it is 1 -> WB.
- WB: one cycle.
  - `npc_i[1:0]`!=0 -> HALT, set `illegal_o`; the PC is not updated, `rf_we`=0 and `instret_o` does not increment.
  - Otherwise `pc_o` <= `npc_i`, `instret_o`+1, and `rf_we`=1 for opcodes that write rd -> FETCH_REQ.
- HALT: absorbing; all request outputs and `rf_we` stay 0; only `rst` leaves this state.

Opcode rules:
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, MISC-MEM, and SYSTEM (`ebreak` only).
- `rf_we`=1 in WB for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32 and OP-32.
- `rf_we`=0 in WB for BRANCH, STORE and MISC-MEM.
- `rf_we` is asserted even when rd=x0; the register file discards writes to x0.

Handshakes and counters:
- A valid, once raised, is held with stable address until ready is seen in the same cycle.
- Response valids are ignored in every state except the matching WAIT state.
- Both 64-bit counters wrap modulo 2^64.
- `cycle_o` increments every cycle that `rst` is 0, including in HALT.

## Timing
- Reset values:
  - `pc_o`=`imem_addr`=`RESET_PC`, `inst_o`=`NOP_INST`.
  - State = FETCH_REQ.
  - All valids, `rf_we`, `halt_o` and `illegal_o` = 0; both counters = 0.
  - Valids are 0 while `rst`=1. `imem_req_valid` rises in the first cycle after `rst` falls.
- Minimum latency, from FETCH_REQ entry to the next FETCH_REQ entry, with ready and response arriving one cycle apart:
  - Non-memory instruction: 5 cycles.
  - Load/store: 7 cycles.
- The memory returns a response no earlier than the cycle after it accepts the request. A response in the acceptance cycle is a protocol violation and is not captured.
- `rst` asserted in any state, including mid-handshake, returns the block to the reset values on the next edge. The memories are reset by the same `rst`, so no stale response follows.
- Decode and execute are combinational from `inst_o`/`pc_o`; `opcode_i` and `npc_i` are stable from DECODE onward.

## Structure
- Shared define header:
  - Opcode constants.
  - The `ebreak` encoding.
  - State encodings (3 bits).
  - `RESET_PC` and `NOP_INST` defaults.
- Sub-module `opc_class`: combinational, `opcode_i` -> {supported, writes_rd, is_mem, is_system}. It is instantiated once in the sequencer.

## Test plan
- Reset, then `imem` with ready=1 always and a 1-cycle response returning `addi x1,x0,5` at 0x8000_0000 -> `rf_we` pulses in cycle 5 after reset release; `pc_o`=0x8000_0004; `instret_o`=1.
- `lw` with `dmem_req_ready` delayed 3 cycles -> `dmem_req_valid` held 4 cycles with no drop; `rf_we` pulses once after `dmem_rsp_valid`; total 10 cycles.
- `beq` taken, `npc_i`=0x8000_0100 -> `rf_we`=0; next `imem_addr`=0x8000_0100.
- `ebreak` (0x0010_0073) -> `halt_o`=1, no further `imem_req_valid`, `instret_o` unchanged, `cycle_o` still counting.
- Opcode 7'b1111111, then separately `jalr` with `npc_i`=0x8000_0002 -> `illegal_o`=1 and HALT; PC unchanged in the misaligned case.
- `rst` pulsed for 1 cycle while in MEM_WAIT, with a spurious `imem_rsp_valid` in FETCH_REQ afterwards -> all outputs at reset values, `inst_o` stays `NOP_INST` until a real FETCH_WAIT response.
